tug_field_n: RTL

//  Parametrised Tug-of-War playfield: NUM_LEDS-wide light bar, edge-qualified L/R presses, multi-round match.

---
 rtl/tug_pkg.sv | 27 ++
 rtl/seg7_digit.sv | 18 +
 rtl/tug_field_n.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/tug_pkg.sv
// Shared types and 7-segment constants for the tug-of-war playfield.
package tug_pkg;

    // Round flow: play a round, hold the result for a gap, or stop for good.
    typedef enum logic [1:0] {
        PLAY       = 2'd0,
        GAP        = 2'd1,
        MATCH_OVER = 2'd2
    } state_t;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000   // 9
    };

endpackage

// File: rtl/seg7_digit.sv
// One active-low 7-segment decoder; values above 9 show a blank digit.
module seg7_digit
    import tug_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] seg
);

    // Look up the digit pattern, blanking anything that is not a decimal digit.
    always_comb begin
        // NOTE: assign every combinational output a default first so no path leaves it unassigned (which would infer a latch).
        seg = SEG_BLANK;
        if (value <= 4'd9) begin
            seg = SEG_DIGIT[value];
        end
    end

endmodule

// File: rtl/tug_field_n.sv
// Tug-of-war playfield: light bar driven by edge-qualified presses, multi-round
// scoring on two 7-seg digits, automatic round restart and match end.
module tug_field_n
    import tug_pkg::*;
#(
    parameter int NUM_LEDS  = 9,
    parameter int SCORE_MAX = 3,
    parameter int ROUND_GAP = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pressL,
    input  logic                pressR,
    output logic [NUM_LEDS:1]   LEDR,
    output logic [6:0]          resultL,
    output logic [6:0]          resultR,
    output logic                round_over,
    output logic                match_over
);

    // Position, score and gap counter widths. A one-cycle gap still needs a
    // one-bit counter so the compare below stays well formed.
    localparam int PW = $clog2(NUM_LEDS);
    localparam int SW = $clog2(SCORE_MAX + 1);
    localparam int GW = (ROUND_GAP > 1) ? $clog2(ROUND_GAP) : 1;

    localparam logic [PW-1:0] CTR       = PW'((NUM_LEDS - 1) / 2);
    localparam logic [PW-1:0] POS_LEFT  = PW'(NUM_LEDS - 1);
    localparam logic [PW-1:0] POS_RIGHT = '0;
    localparam logic [SW-1:0] SCORE_TOP = SW'(SCORE_MAX);
    localparam logic [GW-1:0] GAP_LAST  = GW'(ROUND_GAP - 1);

    // Registered state.
    state_t          state;
    logic [PW-1:0]   pos;
    logic [GW-1:0]   gap_cnt;
    logic [SW-1:0]   score_l;
    logic [SW-1:0]   score_r;
    logic            round_over_q;
    logic            pressl_q;
    logic            pressr_q;

    // Next-state values.
    state_t          state_d;
    logic [PW-1:0]   pos_d;
    logic [GW-1:0]   gap_cnt_d;
    logic [SW-1:0]   score_l_d;
    logic [SW-1:0]   score_r_d;
    logic            round_over_d;

    // A press only counts on its rising edge, and only when the other player
    // did not also rise on the same cycle.
    logic rise_l;
    logic rise_r;
    logic move_l;
    logic move_r;

    assign rise_l = pressL & ~pressl_q;
    assign rise_r = pressR & ~pressr_q;
    assign move_l = rise_l & ~rise_r;
    assign move_r = rise_r & ~rise_l;

    // Next-state logic: move the light, award rounds, run the gap timer.
    always_comb begin
        state_d      = state;
        pos_d        = pos;
        gap_cnt_d    = gap_cnt;
        score_l_d    = score_l;
        score_r_d    = score_r;
        round_over_d = 1'b0;

        case (state)
            PLAY: begin
                if (move_l) begin
                    if (pos == POS_LEFT) begin
                        // Left pulled the light off its end: round to L.
                        score_l_d    = score_l + SW'(1);
                        round_over_d = 1'b1;
                        gap_cnt_d    = '0;
                        state_d      = (score_l_d == SCORE_TOP) ? MATCH_OVER : GAP;
                    end else begin
                        pos_d = pos + PW'(1);
                    end
                end else if (move_r) begin
                    if (pos == POS_RIGHT) begin
                        // Right pulled the light off its end: round to R.
                        score_r_d    = score_r + SW'(1);
                        round_over_d = 1'b1;
                        gap_cnt_d    = '0;
                        state_d      = (score_r_d == SCORE_TOP) ? MATCH_OVER : GAP;
                    end else begin
                        pos_d = pos - PW'(1);
                    end
                end
            end

            GAP: begin
                // Hold the result; presses are ignored until the next round.
                if (gap_cnt == GAP_LAST) begin
                    state_d   = PLAY;
                    pos_d     = CTR;
                    gap_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt + GW'(1);
                end
            end

            MATCH_OVER: begin
                // Frozen until reset.
            end

            default: begin
                state_d = PLAY;
                pos_d   = CTR;
            end
        endcase
    end

    // State register; reset wins over any press activity on the same edge.
    always_ff @(posedge clk) begin
        // NOTE: registered state uses non-blocking assignments so every flop samples the pre-edge values.
        if (reset) begin
            state        <= PLAY;
            pos          <= CTR;
            gap_cnt      <= '0;
            score_l      <= '0;
            score_r      <= '0;
            round_over_q <= 1'b0;
            pressl_q     <= 1'b0;
            pressr_q     <= 1'b0;
        end else begin
            state        <= state_d;
            pos          <= pos_d;
            gap_cnt      <= gap_cnt_d;
            score_l      <= score_l_d;
            score_r      <= score_r_d;
            round_over_q <= round_over_d;
            // History follows the buttons in every state, so a button held
            // through a gap never looks like a fresh press afterwards.
            pressl_q     <= pressL;
            pressr_q     <= pressR;
        end
    end

    // The bar is lit only while a round is in play; position 0 is LEDR[1].
    assign LEDR       = (state == PLAY) ? (NUM_LEDS'(1) << pos) : '0;
    assign round_over = round_over_q;
    assign match_over = (state == MATCH_OVER);

    seg7_digit u_seg_l (
        .value (4'(score_l)),
        .seg   (resultL)
    );

    seg7_digit u_seg_r (
        .value (4'(score_r)),
        .seg   (resultR)
    );

endmodule
